// File: rtl/ks_pkg.sv
// Shared constants and the generate/propagate pair type for the 4-bit Kogge-Stone adder.
// The adder top is kogge_stone_add4. Defining KS4_OVF_EN adds the signed-overflow outputs ovf and ovf_q.
package ks_pkg;

  localparam int WIDTH  = 4;
  localparam int LEVELS = 2;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_leaf(input logic a_bit, input logic b_bit);
    gp_t r;
    r.g = a_bit & b_bit;
    r.p = a_bit ^ b_bit;
    return r;
  endfunction

endpackage

// File: rtl/ks_gp_cell.sv
// Black prefix cell that merges a high (G,P) group with the adjacent low group.
// A grey cell is this same cell with its P output left unused.
module ks_gp_cell
  import ks_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t out
);

  assign out.g = hi.g | (hi.p & lo.g);
  assign out.p = hi.p & lo.p;

endmodule

// File: rtl/kogge_stone_add4.sv
// 4-bit Kogge-Stone adder with a combinational result and a 1-cycle registered copy.
// Defining KS4_OVF_EN adds the signed-overflow outputs ovf (comb) and ovf_q (registered).
module kogge_stone_add4
  import ks_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef KS4_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  gp_t [WIDTH-1:0]  gp [0:LEVELS];
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] top_p_unused;

  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  genvar i, lv;

  // Level 0: per-bit generate/propagate, with cin folded into bit 0's generate
  for (i = 0; i < WIDTH; i++) begin : g_leaf
    assign prop[i] = a[i] ^ b[i];
    if (i == 0) begin : g_bit0
      assign gp[0][i].g = (a[i] & b[i]) | (prop[i] & cin);
      assign gp[0][i].p = prop[i];
    end else begin : g_bitn
      assign gp[0][i] = gp_leaf(a[i], b[i]);
    end
  end

  for (lv = 1; lv <= LEVELS; lv++) begin : g_level
    localparam int SPAN = 1 << (lv - 1);
    for (i = 0; i < WIDTH; i++) begin : g_col
      if (i >= SPAN) begin : g_cell
        ks_gp_cell u_cell (
          .hi  (gp[lv-1][i]),
          .lo  (gp[lv-1][i-SPAN]),
          .out (gp[lv][i])
        );
      end else begin : g_pass
        assign gp[lv][i] = gp[lv-1][i];
      end
    end
  end

  // After the last level every group reaches bit 0, so G is the carry and P is dead
  for (i = 0; i < WIDTH; i++) begin : g_carry
    assign carry[i]        = gp[LEVELS][i].g;
    assign top_p_unused[i] = gp[LEVELS][i].p;
  end

  assign sum  = prop ^ {carry[WIDTH-2:0], cin};
  assign cout = carry[WIDTH-1];

  // Stage p0 -> p1: registered result, captured only when the input is qualified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum;
        cout_p1 <= cout;
      end
    end
  end

  assign sum_q     = sum_p1;
  assign cout_q    = cout_p1;
  assign out_valid = vld_p1;

`ifdef KS4_OVF_EN
  logic ovf_p1;

  assign ovf = carry[WIDTH-2] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      ovf_p1 <= ovf;
    end
  end

  assign ovf_q = ovf_p1;
`endif

endmodule

// File: tb/tb_kogge_stone_add4.sv
// Scoreboard bench for kogge_stone_add4: arithmetic reference model, queued registered results.
module tb_kogge_stone_add4;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       cin, in_valid;
  logic [3:0] sum, sum_q;
  logic       cout, cout_q, out_valid;
`ifdef KS4_OVF_EN
  logic       ovf, ovf_q;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  exp_t sb[$];
  exp_t last_q;

  always #5 clk = ~clk;

  kogge_stone_add4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
`ifdef KS4_OVF_EN
    ,
    .ovf       (ovf),
    .ovf_q     (ovf_q)
`endif
  );

  // Reference: plain integer addition, signed range test for overflow
  function automatic exp_t model(input int av, input int bv, input int cv);
    exp_t e;
    int   total, sa, sb_v, ss;
    total  = av + bv + cv;
    e.sum  = total[3:0];
    e.cout = (total > 15);
    sa     = (av > 7) ? av - 16 : av;
    sb_v   = (bv > 7) ? bv - 16 : bv;
    ss     = sa + sb_v + cv;
    e.ovf  = (ss > 7) || (ss < -8);
    return e;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp_v, $time);
    end
  endtask

  task automatic check_comb(input string tag);
    exp_t e;
    e = model(int'(a), int'(b), int'(cin));
    check({tag, "_sum"}, {4'd0, sum}, {4'd0, e.sum});
    check({tag, "_cout"}, {7'd0, cout}, {7'd0, e.cout});
`ifdef KS4_OVF_EN
    check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, e.ovf});
`endif
  endtask

  task automatic drive(input int av, input int bv, input int cv, input bit vld);
    @(posedge clk);
    #1;
    a        = 4'(av);
    b        = 4'(bv);
    cin      = 1'(cv);
    in_valid = vld;
    if (vld) sb.push_back(model(av, bv, cv));
  endtask

  // Monitor: comb result every cycle, registered result popped when out_valid
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      last_q = '{sum: 4'd0, cout: 1'b0, ovf: 1'b0};
      #1;
      check("rst_sum_q", {4'd0, sum_q}, 8'd0);
      check("rst_cout_q", {7'd0, cout_q}, 8'd0);
      check("rst_out_valid", {7'd0, out_valid}, 8'd0);
`ifdef KS4_OVF_EN
      check("rst_ovf_q", {7'd0, ovf_q}, 8'd0);
`endif
      check_comb("rst_comb");
    end else begin
      check_comb("comb");
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty out_valid=1 with nothing expected at %0t", $time);
        end else begin
          e = sb.pop_front();
          last_q = e;
        end
      end
      check("sum_q", {4'd0, sum_q}, {4'd0, last_q.sum});
      check("cout_q", {7'd0, cout_q}, {7'd0, last_q.cout});
`ifdef KS4_OVF_EN
      check("ovf_q", {7'd0, ovf_q}, {7'd0, last_q.ovf});
`endif
      if (done) begin
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    a        = 4'd3;
    b        = 4'd4;
    cin      = 1'b0;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;

    drive(5, 9, 1, 1'b1);
    drive(1, 1, 0, 1'b0);
    drive(0, 0, 0, 1'b0);
    drive(15, 0, 1, 1'b1);
    drive(15, 15, 1, 1'b1);
    drive(7, 1, 0, 1'b1);
    drive(8, 8, 0, 1'b1);
    drive(3, 2, 0, 1'b1);

    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          drive(x, y, c, $urandom_range(0, 3) != 0);

    // Reset between edges with a result already captured and one more in flight
    drive(6, 7, 0, 1'b1);
    drive(9, 9, 1, 1'b1);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int n = 0; n < 200; n++)
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), $urandom_range(0, 1) == 1);

    drive(0, 0, 0, 1'b0);
    drive(0, 0, 0, 1'b0);
    drive(0, 0, 0, 1'b0);
    done = 1'b1;

    repeat (20) @(posedge clk);
    $display("FAIL timeout monitor did not finish");
    $fatal(1, "timeout");
  end

endmodule
